// File: rtl/seven_seg_scan_reader.sv
// seven_seg_scan_reader
// Snoops a multiplexed active-low seven-segment bus (segments + anodes) and
// recovers the hex value shown on each digit. A digit is only accepted after
// its anode/segment pair has been seen unchanged for STABLE_CYCLES consecutive
// qualified samples, which filters scan edges and ghosting. Patterns that are
// not in the hex glyph table are flagged instead of decoded.
//
// There is no handshake: every rising edge is a sample. A sample qualifies only
// when exactly one anode line is low; anything else is treated as blanking.

module seven_seg_scan_reader #(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            seg_in,
  input  logic [N_DIGITS-1:0]   an_in,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [N_DIGITS-1:0]   digit_valid,
  output logic [N_DIGITS-1:0]   bad_pattern,
  output logic                  frame_done
);

  // Counter wide enough to hold STABLE_CYCLES itself; it saturates there.
  localparam int             CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);
  localparam logic [6:0]     SEG_BLANK = 7'b1111111;

  // Inverse of the hex-to-segment table. Returns {legal, value}; bit 6 of the
  // pattern is segment a, bit 0 is segment g, all active-low.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    logic [4:0] res;
    res = 5'b0_0000;
    case (pat)
      7'b0000001: res = 5'b1_0000;
      7'b1001111: res = 5'b1_0001;
      7'b0010010: res = 5'b1_0010;
      7'b0000110: res = 5'b1_0011;
      7'b1001100: res = 5'b1_0100;
      7'b0100100: res = 5'b1_0101;
      7'b0100000: res = 5'b1_0110;
      7'b0001111: res = 5'b1_0111;
      7'b0000000: res = 5'b1_1000;
      7'b0000100: res = 5'b1_1001;
      7'b0001000: res = 5'b1_1010;
      7'b1100000: res = 5'b1_1011;
      7'b0110001: res = 5'b1_1100;
      7'b1000010: res = 5'b1_1101;
      7'b0110000: res = 5'b1_1110;
      7'b0111000: res = 5'b1_1111;
      default:    res = 5'b0_0000;
    endcase
    return res;
  endfunction

  // Sampling / stability state.
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [N_DIGITS-1:0]   prev_an_q, prev_an_d;
  logic [6:0]            prev_seg_q, prev_seg_d;

  // Output and frame state.
  logic [4*N_DIGITS-1:0] digits_q, digits_d;
  logic [N_DIGITS-1:0]   valid_q, valid_d;
  logic [N_DIGITS-1:0]   bad_q, bad_d;
  logic [N_DIGITS-1:0]   seen_q, seen_d;
  logic                  frame_q, frame_d;

  // Combinational helpers.
  logic [N_DIGITS-1:0]   an_act;
  logic                  one_hot;
  logic                  same_ref;
  logic                  accept;
  logic [4:0]            dec;
  logic                  pat_legal;
  logic                  pat_blank;
  logic [N_DIGITS-1:0]   seen_or;

  // Qualify the sample: the active-high anode vector must be exactly one-hot.
  always_comb begin
    an_act  = ~an_in;
    one_hot = (an_act != '0) &&
              ((an_act & (an_act - N_DIGITS'(1))) == '0);
  end

  // Stability counter and reference tracking. A count of zero means there is
  // no reference (reset or a blanking cycle broke the run), so the next
  // qualified sample always starts a fresh dwell at 1.
  always_comb begin
    same_ref   = (cnt_q != '0) && (an_in == prev_an_q) && (seg_in == prev_seg_q);
    cnt_d      = cnt_q;
    prev_an_d  = prev_an_q;
    prev_seg_d = prev_seg_q;
    if (!one_hot) begin
      cnt_d = '0;
    end else if (same_ref) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    end else begin
      cnt_d      = CNT_ONE;
      prev_an_d  = an_in;
      prev_seg_d = seg_in;
    end
    // Accept only on the edge where the count reaches the threshold; a count
    // already sitting at saturation on a continuing dwell does not re-accept.
    accept = one_hot && (cnt_d == CNT_MAX) && !(same_ref && (cnt_q == CNT_MAX));
  end

  // Per-digit output update for the anode being accepted; others hold.
  always_comb begin
    dec       = decode_seg(seg_in);
    pat_legal = dec[4];
    pat_blank = (seg_in == SEG_BLANK);
    digits_d  = digits_q;
    valid_d   = valid_q;
    bad_d     = bad_q;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (accept && an_act[i]) begin
        if (pat_legal) begin
          digits_d[4*i +: 4] = dec[3:0];
          valid_d[i]         = 1'b1;
          bad_d[i]           = 1'b0;
        end else if (pat_blank) begin
          valid_d[i] = 1'b0;
          bad_d[i]   = 1'b0;
        end else begin
          valid_d[i] = 1'b0;
          bad_d[i]   = 1'b1;
        end
      end
    end
  end

  // Frame tracking: any accept marks its digit seen. When the mask fills, the
  // pulse fires and the mask restarts empty, so an accept landing on that
  // same edge belongs to the finished frame, not the new one.
  always_comb begin
    seen_or = seen_q | (accept ? an_act : '0);
    frame_d = (seen_or == {N_DIGITS{1'b1}});
    seen_d  = frame_d ? '0 : seen_or;
  end

  // Sampling state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      prev_an_q  <= '0;
      prev_seg_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      prev_an_q  <= prev_an_d;
      prev_seg_q <= prev_seg_d;
    end
  end

  // Output and frame registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_q <= '0;
      valid_q  <= '0;
      bad_q    <= '0;
      seen_q   <= '0;
      frame_q  <= 1'b0;
    end else begin
      digits_q <= digits_d;
      valid_q  <= valid_d;
      bad_q    <= bad_d;
      seen_q   <= seen_d;
      frame_q  <= frame_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign bad_pattern = bad_q;
  assign frame_done  = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_reader.sv
// Testbench for seven_seg_scan_reader (N_DIGITS=4, STABLE_CYCLES=4).
// A behavioural model tracks run length of identical qualified samples and
// the glyph table, and every scenario task compares the DUT against it.

module tb_seven_seg_scan_reader;

  localparam int N = 4;
  localparam int S = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [6:0]   seg_in = 7'h7F;
  logic [N-1:0] an_in  = '1;
  logic [4*N-1:0] digits;
  logic [N-1:0]   digit_valid;
  logic [N-1:0]   bad_pattern;
  logic           frame_done;

  seven_seg_scan_reader #(.N_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .clk(clk),
    .reset(reset),
    .seg_in(seg_in),
    .an_in(an_in),
    .digits(digits),
    .digit_valid(digit_valid),
    .bad_pattern(bad_pattern),
    .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;

  // Glyph table, index = hex value.
  logic [6:0] tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference model state
  int             run;
  logic [N-1:0]   ref_an;
  logic [6:0]     ref_seg;
  logic [4*N-1:0] exp_digits;
  logic [N-1:0]   exp_valid;
  logic [N-1:0]   exp_bad;
  logic [N-1:0]   seen;
  logic           exp_fd;

  // Scoreboard queue of expected recovered values
  logic [3:0] exp_q[$];

  task automatic model_reset();
    run = 0; ref_an = '0; ref_seg = '0;
    exp_digits = '0; exp_valid = '0; exp_bad = '0; seen = '0; exp_fd = 1'b0;
  endtask

  // Applied once per rising edge with the inputs the DUT saw on that edge.
  task automatic model_step();
    int zeros;
    int idx;
    int val;
    zeros = 0; idx = 0; val = -1;
    exp_fd = 1'b0;
    for (int i = 0; i < N; i++) if (an_in[i] == 1'b0) begin zeros++; idx = i; end
    if (zeros != 1) begin
      run = 0;
    end else begin
      if (run > 0 && an_in == ref_an && seg_in == ref_seg) run++;
      else begin run = 1; ref_an = an_in; ref_seg = seg_in; end
      if (run == S) begin
        for (int v = 0; v < 16; v++) if (tab[v] == seg_in) val = v;
        if (val >= 0) begin
          exp_digits[idx*4 +: 4] = 4'(val);
          exp_valid[idx] = 1'b1;
          exp_bad[idx] = 1'b0;
        end else if (seg_in == 7'h7F) begin
          exp_valid[idx] = 1'b0;
          exp_bad[idx] = 1'b0;
        end else begin
          exp_valid[idx] = 1'b0;
          exp_bad[idx] = 1'b1;
        end
        seen[idx] = 1'b1;
        if (seen == '1) begin exp_fd = 1'b1; seen = '0; end
      end
    end
  endtask

  // Driver: present one sample for one rising edge, then settle past it.
  task automatic drive(input logic [N-1:0] a, input logic [6:0] s);
    an_in = a;
    seg_in = s;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic reset_on();
    reset = 1'b1;
    #1;
    model_reset();
  endtask

  task automatic reset_off();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset_on();
    checks++;
    if ({digits, digit_valid, bad_pattern, frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_state: got dig=%h val=%b bad=%b fd=%b want all zero",
               digits, digit_valid, bad_pattern, frame_done);
    end
    reset_off();
  endtask

  task automatic test_single_accept();
    reset_on(); reset_off();
    for (int k = 0; k < 14; k++) begin
      drive(4'b1110, 7'b0000110);
      checks++;
      if ({digits, digit_valid, bad_pattern, frame_done} !== {exp_digits, exp_valid, exp_bad, exp_fd}) begin
        errors++;
        $display("FAIL single_cycle%0d: got dig=%h val=%b bad=%b fd=%b want dig=%h val=%b bad=%b fd=%b",
                 k, digits, digit_valid, bad_pattern, frame_done, exp_digits, exp_valid, exp_bad, exp_fd);
      end
      if (k == 2 || k == 3 || k == 13) begin
        checks++;
        if (digit_valid !== ((k >= 3) ? 4'b0001 : 4'b0000) || (k >= 3 && digits[3:0] !== 4'd3)) begin
          errors++;
          $display("FAIL single_latency%0d: got val=%b dig0=%h want val=%b dig0=3",
                   k, digit_valid, digits[3:0], (k >= 3) ? 4'b0001 : 4'b0000);
        end
      end
    end
  endtask

  task automatic test_scan();
    logic [3:0] vals [4];
    int pulses;
    vals = '{4'h5, 4'hA, 4'hD, 4'h8};
    pulses = 0;
    reset_on(); reset_off();
    for (int d = 0; d < N; d++) begin
      exp_q.push_back(vals[d]);
      for (int k = 0; k < 6; k++) begin
        drive(4'(~(4'b0001 << d)), tab[vals[d]]);
        if (frame_done) pulses++;
        checks++;
        if ({digits, digit_valid, bad_pattern, frame_done} !== {exp_digits, exp_valid, exp_bad, exp_fd}) begin
          errors++;
          $display("FAIL scan_d%0d_c%0d: got dig=%h val=%b bad=%b fd=%b want dig=%h val=%b bad=%b fd=%b",
                   d, k, digits, digit_valid, bad_pattern, frame_done, exp_digits, exp_valid, exp_bad, exp_fd);
        end
        if (d == 3 && k == 3) begin
          checks++;
          if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL scan_frame_edge: got fd=%b want 1", frame_done);
          end
        end
      end
    end
    for (int d = 0; d < N; d++) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      checks++;
      if (digits[4*d +: 4] !== e) begin
        errors++;
        $display("FAIL scan_digit%0d: got %h want %h", d, digits[4*d +: 4], e);
      end
    end
    checks++;
    if (digits !== 16'h8DA5 || digit_valid !== 4'hF || pulses != 1) begin
      errors++;
      $display("FAIL scan_final: got dig=%h val=%b pulses=%0d want dig=8da5 val=1111 pulses=1",
               digits, digit_valid, pulses);
    end
  endtask

  task automatic test_glitch();
    reset_on(); reset_off();
    for (int k = 0; k < 3; k++) drive(4'b1101, 7'b0000110);
    drive(4'b1101, 7'b0100100);
    checks++;
    if (digit_valid !== 4'b0000 || digit_valid !== exp_valid) begin
      errors++;
      $display("FAIL glitch_no_accept: got val=%b want 0000", digit_valid);
    end
    for (int k = 0; k < 4; k++) begin
      drive(4'b1101, 7'b0100100);
      checks++;
      if ({digits, digit_valid, bad_pattern, frame_done} !== {exp_digits, exp_valid, exp_bad, exp_fd}) begin
        errors++;
        $display("FAIL glitch_c%0d: got dig=%h val=%b bad=%b fd=%b want dig=%h val=%b bad=%b fd=%b",
                 k, digits, digit_valid, bad_pattern, frame_done, exp_digits, exp_valid, exp_bad, exp_fd);
      end
    end
    checks++;
    if (digits[7:4] !== 4'd5 || digit_valid !== 4'b0010) begin
      errors++;
      $display("FAIL glitch_final: got dig1=%h val=%b want 5 0010", digits[7:4], digit_valid);
    end
  endtask

  task automatic test_ghost();
    reset_on(); reset_off();
    for (int k = 0; k < 8; k++) begin
      drive(4'b1100, 7'b0001111);
      checks++;
      if ({digits, digit_valid, bad_pattern, frame_done} !== '0) begin
        errors++;
        $display("FAIL ghost_c%0d: got dig=%h val=%b bad=%b fd=%b want all zero",
                 k, digits, digit_valid, bad_pattern, frame_done);
      end
    end
    for (int k = 0; k < 4; k++) begin
      drive(4'b1011, 7'b0001111);
      checks++;
      if (digit_valid !== ((k == 3) ? 4'b0100 : 4'b0000) || digit_valid !== exp_valid) begin
        errors++;
        $display("FAIL ghost_resume_c%0d: got val=%b want %b", k, digit_valid,
                 (k == 3) ? 4'b0100 : 4'b0000);
      end
    end
    checks++;
    if (digits[11:8] !== 4'd7) begin
      errors++;
      $display("FAIL ghost_value: got %h want 7", digits[11:8]);
    end
  endtask

  task automatic test_bad_pattern();
    reset_on(); reset_off();
    for (int k = 0; k < 4; k++) drive(4'b1011, 7'b0100000);
    for (int k = 0; k < 4; k++) drive(4'b1011, 7'b1010101);
    checks++;
    if (bad_pattern !== 4'b0100 || digit_valid !== 4'b0000 || digits[11:8] !== 4'd6) begin
      errors++;
      $display("FAIL bad_illegal: got bad=%b val=%b dig2=%h want 0100 0000 6",
               bad_pattern, digit_valid, digits[11:8]);
    end
    for (int k = 0; k < 4; k++) drive(4'b1011, 7'b1111111);
    checks++;
    if (bad_pattern !== 4'b0000 || digit_valid !== 4'b0000 || digits[11:8] !== 4'd6) begin
      errors++;
      $display("FAIL bad_blank: got bad=%b val=%b dig2=%h want 0000 0000 6",
               bad_pattern, digit_valid, digits[11:8]);
    end
    checks++;
    if ({digits, digit_valid, bad_pattern} !== {exp_digits, exp_valid, exp_bad}) begin
      errors++;
      $display("FAIL bad_model: got dig=%h val=%b bad=%b want dig=%h val=%b bad=%b",
               digits, digit_valid, bad_pattern, exp_digits, exp_valid, exp_bad);
    end
  endtask

  task automatic test_reset_mid();
    reset_on(); reset_off();
    for (int k = 0; k < 4; k++) drive(4'b0111, 7'b0000110);
    for (int k = 0; k < 3; k++) drive(4'b1110, 7'b0000110);
    reset_on();
    checks++;
    if ({digits, digit_valid, bad_pattern, frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_mid_clear: got dig=%h val=%b bad=%b fd=%b want all zero",
               digits, digit_valid, bad_pattern, frame_done);
    end
    reset_off();
    for (int k = 0; k < 4; k++) begin
      drive(4'b1110, 7'b0000110);
      checks++;
      if (digit_valid !== ((k == 3) ? 4'b0001 : 4'b0000) || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_c%0d: got val=%b fd=%b want val=%b fd=0", k, digit_valid,
                 frame_done, (k == 3) ? 4'b0001 : 4'b0000);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a;
    logic [6:0]   s;
    int len;
    int r;
    reset_on(); reset_off();
    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = '1;
      else if (r == 1) a = 4'($urandom_range(0, 15));
      else a = 4'(~(4'b0001 << $urandom_range(0, N - 1)));
      r = $urandom_range(0, 9);
      if (r <= 6) s = tab[$urandom_range(0, 15)];
      else if (r == 7) s = 7'h7F;
      else s = 7'($urandom_range(0, 127));
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) begin
        drive(a, s);
        checks++;
        if ({digits, digit_valid, bad_pattern, frame_done} !== {exp_digits, exp_valid, exp_bad, exp_fd}) begin
          errors++;
          $display("FAIL random_t%0d_c%0d: got dig=%h val=%b bad=%b fd=%b want dig=%h val=%b bad=%b fd=%b",
                   t, k, digits, digit_valid, bad_pattern, frame_done, exp_digits, exp_valid, exp_bad, exp_fd);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_accept();
    test_scan();
    test_glitch();
    test_ghost();
    test_bad_pattern();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_reader.md
Name: seven_seg_scan_reader

Overview:
- Receive-side counterpart of the hex-to-segment decoder: snoops a multiplexed, active-low seven-segment bus (segments plus anodes) and recovers the 4-bit hex value shown on each digit.
- Used by board self-test and by the counter bench to check the display path end to end.
- Filters scan transitions and ghosting with a per-dwell stability check, and flags illegal segment patterns.

Parameters:
- N_DIGITS, 4, number of anode lines and recovered digits (1..8).
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is accepted (>=1).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- seg_in  input  7  segment bus, active-low, bit6=a … bit0=g.
- an_in  input  N_DIGITS  anode enables, active-low, bit i = digit i.
- digits  output  4*N_DIGITS  recovered values; digit i at [4i+3:4i].
- digit_valid  output  N_DIGITS  bit i set = digit i holds an accepted legal value.
- bad_pattern  output  N_DIGITS  bit i set = last accepted pattern on digit i was illegal.
- frame_done  output  1  one-cycle pulse when every digit has been accepted since the previous pulse or reset.

Behaviour:
- Reset (async assert, sync release) clears all of the following:
  - digits = 0, digit_valid = 0, bad_pattern = 0, frame_done = 0.
  - Internal state: sample count, previous anode/pattern registers, frame-seen mask.
- Sample qualification, each rising edge:
  - A sample is valid only when exactly one bit of an_in is 0.
  - Zero or multiple active anodes is a blanking/ghost cycle: the count goes to 0 and nothing is accepted.
- Stability count (width clog2(STABLE_CYCLES+1)):
  - Valid sample with the same anode and same seg_in as the previous valid sample (no invalid cycle in between): count increments, saturating at STABLE_CYCLES.
  - Any other valid sample: count = 1, and it becomes the new reference.
- Accept event:
  - Occurs on the edge where the count becomes STABLE_CYCLES. For STABLE_CYCLES=1, every first sample accepts.
  - Outputs update on that same edge, so latency is STABLE_CYCLES edges from pattern appearance.
  - Exactly one accept per dwell; a saturated count does not re-accept.
- Inverse table (seg_in -> value):
  - 0000001->0, 1001111->1, 0010010->2, 0000110->3
  - 1001100->4, 0100100->5, 0100000->6, 0001111->7
  - 0000000->8, 0000100->9, 0001000->A, 1100000->b
  - 0110001->C, 1000010->d, 0110000->E, 0111000->F
- On accept for digit i:
  - Legal pattern: digits[i] = value, digit_valid[i] = 1, bad_pattern[i] = 0.
  - 1111111 (blank): digit_valid[i] = 0, bad_pattern[i] = 0, digits[i] held.
  - Any other pattern: digit_valid[i] = 0, bad_pattern[i] = 1, digits[i] held.
  - Other digits are unaffected in all cases.
- frame_done:
  - Each accept (any kind) sets seen[i].
  - On the edge where seen becomes all-ones, frame_done = 1 for exactly one cycle and seen clears to 0 on that same edge.
  - An accept on that same edge is dropped from the new frame; the next accept starts the new frame.
- Anode change mid-dwell resets the count; there is no partial accept.
- Reset asserted mid-dwell or mid-frame: immediate clear per reset list; no pulse on release.

Test Plan:
- STABLE_CYCLES=4: hold an_in=1110, seg_in=0000110 for 4 cycles -> on 4th edge digits[3:0]=3, digit_valid=0001; holding 10 more cycles produces no further accept.
- Scan digits 0..3 with patterns 5, A, d, 8, each held 6 cycles -> digits=16'h8DA5, digit_valid=1111, frame_done pulses once on the edge digit 3 is accepted.
- Hold seg_in=0000110 for 3 cycles then glitch to 0100100 for 1 cycle on digit 1 -> no accept; stable 0100100 for 4 more cycles -> digit 1 = 5.
- an_in=1100 (two active) for 8 cycles with a legal pattern -> no change to any output; single anode resumes -> accept after 4 edges.
- Digit 2 shows 1010101 for 4 cycles -> bad_pattern[2]=1, digit_valid[2]=0, digits[11:8] unchanged; then 1111111 for 4 cycles -> bad_pattern[2]=0, digit_valid[2]=0.
- Assert reset at count=3 mid-dwell -> all outputs 0 immediately; after release, same pattern needs 4 full edges to accept.
